// File: rtl/sudoku_propagation_engine.sv
// Constraint-propagation core for an N x N Sudoku (N = p_BOX^2): row-major load,
// in-place peer-singleton elimination one cell per clock, solved/stuck/invalid status.
module sudoku_propagation_engine #(
  parameter int unsigned p_BOX        = 3,
  parameter int unsigned p_MAX_PASSES = 32,
  localparam int unsigned N    = p_BOX * p_BOX,
  localparam int unsigned C    = N * N,
  localparam int unsigned VW   = $clog2(N + 1),
  localparam int unsigned AW   = $clog2(C),
  localparam int unsigned PW   = $clog2(p_MAX_PASSES + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Load_Valid,
  input  logic [VW-1:0] i_Load_Value,
  output logic          o_Load_Ready,
  input  logic          i_Start,
  output logic          o_Busy,
  output logic          o_Done,
  output logic          o_Solved,
  output logic          o_Stuck,
  output logic          o_Invalid,
  output logic [PW-1:0] o_Pass_Count,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic [VW-1:0] o_Rd_Value
);

  localparam int unsigned PTRW = $clog2(C + 1);
  localparam int unsigned RCW  = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_SOLVE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    mask_q [C];
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [RCW-1:0]  row_q, row_d, col_q, col_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            changed_q, changed_d, changed_any;
  logic            done_q, done_d, solved_q, solved_d;
  logic            stuck_q, stuck_d, invalid_q, invalid_d;
  logic            busy_q, busy_d, ready_q, ready_d;
  logic [VW-1:0]   rd_q;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [N-1:0]    wr_data;
  logic [N-1:0]    cur_mask, peer_or, new_mask, load_mask, eval_m;
  logic            any_zero, all_single;

  function automatic logic is_single(input logic [N-1:0] m);
    return (m != '0) && ((m & (m - N'(1))) == '0);
  endfunction

  function automatic logic [VW-1:0] decode(input logic [N-1:0] m);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      if (m == (N'(1) << k)) v = VW'(k + 1);
    return v;
  endfunction

  // OR of every singleton peer (same row, column or box) of the current cell
  always_comb begin
    peer_or = '0;
    for (int j = 0; j < C; j++) begin
      if (j != int'(idx_q) && is_single(mask_q[j]) &&
          ((j / N) == int'(row_q) || (j % N) == int'(col_q) ||
           (((j / N) / p_BOX) == (int'(row_q) / p_BOX) &&
            ((j % N) / p_BOX) == (int'(col_q) / p_BOX))))
        peer_or = peer_or | mask_q[j];
    end
  end

  assign cur_mask = mask_q[idx_q];
  assign new_mask = cur_mask & ~peer_or;

  always_comb begin
    load_mask = '0;
    if (i_Load_Value == '0)
      load_mask = '1;
    else if (i_Load_Value <= VW'(N))
      load_mask = N'(1) << (i_Load_Value - VW'(1));
  end

  // Grid status as it stands once the current cell's update lands
  always_comb begin
    any_zero   = 1'b0;
    all_single = 1'b1;
    eval_m     = '0;
    for (int j = 0; j < C; j++) begin
      eval_m = (j == int'(idx_q)) ? new_mask : mask_q[j];
      if (eval_m == '0) any_zero = 1'b1;
      if (!is_single(eval_m)) all_single = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    pass_d      = pass_q;
    changed_d   = changed_q;
    done_d      = done_q;
    solved_d    = solved_q;
    stuck_d     = stuck_q;
    invalid_d   = invalid_q;
    wr_en       = 1'b0;
    wr_addr     = idx_q;
    wr_data     = new_mask;
    changed_any = changed_q | (new_mask != cur_mask);
    case (state_q)
      S_IDLE: begin
        if (i_Load_Valid && ptr_q < PTRW'(C)) begin
          wr_en   = 1'b1;
          wr_addr = AW'(ptr_q);
          wr_data = load_mask;
          ptr_d   = ptr_q + PTRW'(1);
        end else if (i_Start && ptr_q == PTRW'(C)) begin
          state_d   = S_SOLVE;
          idx_d     = '0;
          row_d     = '0;
          col_d     = '0;
          pass_d    = '0;
          changed_d = 1'b0;
        end
      end
      S_SOLVE: begin
        wr_en     = 1'b1;
        changed_d = changed_any;
        if (idx_q == AW'(C - 1)) begin
          pass_d    = pass_q + PW'(1);
          changed_d = 1'b0;
          idx_d     = '0;
          row_d     = '0;
          col_d     = '0;
          if (any_zero)
            invalid_d = 1'b1;
          else if (all_single)
            solved_d = 1'b1;
          else if (!changed_any || pass_d == PW'(p_MAX_PASSES))
            stuck_d = 1'b1;
          if (any_zero || all_single || !changed_any || pass_d == PW'(p_MAX_PASSES)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ptr_d   = '0;
          end
        end else begin
          idx_d = idx_q + AW'(1);
          if (col_q == RCW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + RCW'(1);
          end else begin
            col_d = col_q + RCW'(1);
          end
        end
      end
      S_DONE: begin
        if (i_Load_Valid) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          wr_data   = load_mask;
          ptr_d     = PTRW'(1);
          state_d   = S_IDLE;
          done_d    = 1'b0;
          solved_d  = 1'b0;
          stuck_d   = 1'b0;
          invalid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_SOLVE);
    ready_d = (state_d == S_IDLE && ptr_d < PTRW'(C)) || (state_d == S_DONE);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int j = 0; j < C; j++) mask_q[j] <= '1;
      ptr_q     <= '0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pass_q    <= '0;
      changed_q <= 1'b0;
      done_q    <= 1'b0;
      solved_q  <= 1'b0;
      stuck_q   <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      rd_q      <= '0;
    end else begin
      if (wr_en) mask_q[wr_addr] <= wr_data;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pass_q    <= pass_d;
      changed_q <= changed_d;
      done_q    <= done_d;
      solved_q  <= solved_d;
      stuck_q   <= stuck_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      rd_q      <= (32'(i_Rd_Addr) < C) ? decode(mask_q[i_Rd_Addr]) : '0;
    end
  end

  assign o_Load_Ready = ready_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Solved     = solved_q;
  assign o_Stuck      = stuck_q;
  assign o_Invalid    = invalid_q;
  assign o_Pass_Count = pass_q;
  assign o_Rd_Value   = rd_q;

endmodule

// File: tb/tb_sudoku_propagation_engine.sv
// Scoreboard bench: a 9x9 and a 4x4 engine share stimulus; sel picks the active one.
module tb_sudoku_propagation_engine;

  logic       clk = 1'b0;
  logic       rst, valid, start, sel;
  logic [4:0] val;
  logic [6:0] addr;

  logic       r9, b9, d9, s9, k9, i9;
  logic [5:0] p9;
  logic [3:0] v9;
  logic       r4, b4, d4, s4, k4, i4;
  logic [5:0] p4;
  logic [2:0] v4;

  logic       ready, busy, done, solved, stuck, invalid;
  logic [5:0] pcount;
  logic [3:0] rdv;

  int checks = 0;
  int errors = 0;
  int grid [81];

  typedef struct {string tag; int val;} rd_exp_t;
  typedef struct {int solved; int stuck; int invalid; int passes; int cycles;} st_exp_t;
  rd_exp_t rd_q [$];
  st_exp_t st_q [$];

  int sol9 [81] = '{5,3,4,6,7,8,9,1,2, 6,7,2,1,9,5,3,4,8, 1,9,8,3,4,2,5,6,7,
                    8,5,9,7,6,1,4,2,3, 4,2,6,8,5,3,7,9,1, 7,1,3,9,2,4,8,5,6,
                    9,6,1,5,3,7,2,8,4, 2,8,7,4,1,9,6,3,5, 3,4,5,2,8,6,1,7,9};
  int grid4 [16] = '{1,0,0,0, 0,0,2,0, 0,3,0,0, 0,0,0,4};
  int sol4  [16] = '{1,2,4,3, 3,4,2,1, 4,3,1,2, 2,1,3,4};

  always #5 clk = ~clk;

  sudoku_propagation_engine #(.p_BOX(3), .p_MAX_PASSES(32)) u_dut9 (
    .i_Clk(clk), .i_Rst(rst), .i_Load_Valid(valid & ~sel), .i_Load_Value(val[3:0]),
    .o_Load_Ready(r9), .i_Start(start & ~sel), .o_Busy(b9), .o_Done(d9),
    .o_Solved(s9), .o_Stuck(k9), .o_Invalid(i9), .o_Pass_Count(p9),
    .i_Rd_Addr(addr), .o_Rd_Value(v9));

  sudoku_propagation_engine #(.p_BOX(2), .p_MAX_PASSES(32)) u_dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Load_Valid(valid & sel), .i_Load_Value(val[2:0]),
    .o_Load_Ready(r4), .i_Start(start & sel), .o_Busy(b4), .o_Done(d4),
    .o_Solved(s4), .o_Stuck(k4), .o_Invalid(i4), .o_Pass_Count(p4),
    .i_Rd_Addr(addr[3:0]), .o_Rd_Value(v4));

  assign ready   = sel ? r4 : r9;
  assign busy    = sel ? b4 : b9;
  assign done    = sel ? d4 : d9;
  assign solved  = sel ? s4 : s9;
  assign stuck   = sel ? k4 : k9;
  assign invalid = sel ? i4 : i9;
  assign pcount  = sel ? p4 : p9;
  assign rdv     = sel ? {1'b0, v4} : v9;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Streams grid[] row-major; an i_Start is slipped in before beat ign_at
  task automatic load_grid(input int ign_at);
    int n;
    n = sel ? 16 : 81;
    for (int i = 0; i < n; i++) begin
      if (i == ign_at) begin
        @(negedge clk); valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("early_start_busy", busy, 0);
        chk("early_start_ready", ready, 1);
      end
      @(negedge clk); valid = 1'b1; val = 5'(grid[i]);
      if (i == 1) chk("done_cleared", done, 0);
    end
    @(negedge clk); valid = 1'b0;
    chk("ready_full", ready, 0);
  endtask

  task automatic run(input int abort_at, input int e_sol, input int e_stk,
                     input int e_inv, input int e_pass);
    int n, cyc;
    st_exp_t e;
    n   = sel ? 16 : 81;
    cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("ready_in_solve", ready, 0);
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      chk("pass_before_rst", pcount, 1);
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_status", {solved, stuck, invalid}, 0);
      chk("rst_pass", pcount, 0);
      chk("rst_rd", rdv, 0);
      chk("rst_ready", ready, 1);
      @(negedge clk); rst = 1'b0;
    end else begin
      st_q.push_back('{e_sol, e_stk, e_inv, e_pass, e_pass * n});
      while (!done && cyc < 40 * n) begin
        @(negedge clk);
        cyc++;
      end
      e = st_q.pop_front();
      chk("done", done, 1);
      chk("cycles", cyc, e.cycles);
      chk("solved", solved, e.solved);
      chk("stuck", stuck, e.stuck);
      chk("invalid", invalid, e.invalid);
      chk("passes", pcount, e.passes);
      chk("busy_done", busy, 0);
      chk("ready_done", ready, 1);
    end
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    rd_exp_t e;
    @(negedge clk); addr = 7'(a); rd_q.push_back('{tag, exp});
    @(negedge clk);
    e = rd_q.pop_front();
    chk(e.tag, rdv, e.val);
  endtask

  task automatic set_puzzle1();
    for (int i = 0; i < 81; i++) grid[i] = (i < 9 || i % 9 == 0) ? 0 : sol9[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; start = 1'b0; val = '0; addr = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", ready, 1);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_status0", {solved, stuck, invalid}, 0);
    chk("rst_pass0", pcount, 0);
    chk("rst_rd0", rdv, 0);
    @(negedge clk); rst = 1'b0;
    rd("rst_mask0", 0, 0);

    // Row 0 and column 0 blank: cell 0 resolves only in the second pass
    set_puzzle1();
    load_grid(50);
    @(negedge clk); valid = 1'b1; val = 5'd9;
    @(negedge clk); valid = 1'b0;
    chk("beat82_ready", ready, 0);
    run(0, 1, 0, 0, 2);
    for (int a = 0; a < 81; a++) rd("sol9_cell", a, sol9[a]);

    for (int i = 0; i < 81; i++) grid[i] = 0;
    grid[0] = 5; grid[1] = 5;
    load_grid(-1);
    run(0, 0, 0, 1, 1);
    rd("dup_cell0", 0, 0);
    rd("dup_cell1", 1, 5);

    for (int i = 0; i < 81; i++) grid[i] = 0;
    load_grid(-1);
    run(0, 0, 1, 0, 1);
    rd("empty_c0", 0, 0);
    rd("empty_c40", 40, 0);
    rd("empty_c80", 80, 0);

    set_puzzle1();
    load_grid(-1);
    rd("pre_abort_c80", 80, 9);
    run(100, 0, 0, 0, 0);
    load_grid(-1);
    run(0, 1, 0, 0, 2);
    rd("reload_c0", 0, sol9[0]);
    rd("reload_c40", 40, sol9[40]);
    rd("reload_c80", 80, sol9[80]);

    sel = 1'b1;
    for (int i = 0; i < 16; i++) grid[i] = grid4[i];
    load_grid(-1);
    run(0, 1, 0, 0, 2);
    for (int a = 0; a < 16; a++) rd("sol4_cell", a, sol4[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
